button_event_decoder: RTL
=========================

Name: button_event_decoder

Overview:
- Consumes the cleaned push-button event interface (pressed pulse, pressed status, released pulse) produced by the debouncer.
- Converts it into user-level gestures for the clock/alarm setting logic: short press, double press, long press and auto-repeat while held.
- Sits between each debounced button and the time/alarm set controller.
- All timing is measured in ticks of an external timebase enable (nominally 1 ms), not in raw clocks.

Parameters:
- LONG_TICKS, 1000, ticks held before long_pulse fires (>=2).
- REPEAT_TICKS, 200, ticks between repeat_pulse outputs after long press (>=1).
- GAP_TICKS, 250, max ticks between release and second press for a double press; 0 disables double detection.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  timebase enable, single-cycle, 1 per period
- pb_pressed_pulse  in  1  one-cycle press event
- pb_pressed_status  in  1  high while debounced button held
- pb_released_pulse  in  1  one-cycle release event
- short_pulse  out  1  one-cycle single short press
- double_pulse  out  1  one-cycle double press
- long_pulse  out  1  one-cycle, fires once at long threshold
- repeat_pulse  out  1  one-cycle, periodic while held past long
- held  out  1  level, high in HELD/HELD2/LONG

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, all outputs 0.
- Counter: width = $clog2(max(LONG_TICKS, REPEAT_TICKS, GAP_TICKS)+1). Increments only on tick. Cleared on every state change and on each repeat emission. No wrap: thresholds always exit or clear first.
- All outputs are registered. Pulses assert the cycle after the causing input/tick and last exactly 1 clk.
- IDLE:
  - pb_pressed_pulse -> HELD.
- HELD:
  - released_pulse with GAP_TICKS=0 -> short_pulse, IDLE.
  - released_pulse with GAP_TICKS>0 -> WAIT2.
  - tick with cnt==LONG_TICKS-1 -> long_pulse, LONG.
- LONG:
  - tick with cnt==REPEAT_TICKS-1 -> repeat_pulse, cnt=0.
  - released_pulse -> IDLE. No short_pulse is emitted.
- WAIT2:
  - pb_pressed_pulse -> HELD2.
  - tick with cnt==GAP_TICKS-1 -> short_pulse, IDLE.
- HELD2:
  - released_pulse -> double_pulse, IDLE.
  - tick with cnt==LONG_TICKS-1 -> short_pulse and long_pulse in the same cycle, then LONG. The first press counts as short; the second becomes long.
- Priority in the same cycle:
  - released_pulse beats tick threshold.
  - pb_pressed_pulse in WAIT2 beats gap timeout.
- pb_pressed_pulse in HELD/HELD2/LONG is ignored.
- released_pulse in IDLE/WAIT2 is ignored.
- Abort: in HELD/HELD2/LONG, if pb_pressed_status=0 and no released_pulse that cycle -> IDLE, no pulse output. This covers upstream reset mid-press.
- held is a registered level, 1 while state is HELD, HELD2 or LONG.
- At most one of short/double/long/repeat is high per cycle, except the HELD2 short+long case.
- Reset asserted mid-gesture clears everything immediately. No pulse is emitted on reset release.

Test Plan:
(All cases use LONG_TICKS=4, REPEAT_TICKS=2, GAP_TICKS=3, tick every 2 clk unless stated.)
- Short, no double: press, release after 2 ticks, no press for 3 ticks -> exactly one short_pulse, 1 clk after 3rd gap tick. No other pulses. held high only during the press.
- Double: press 1 tick, release, press again at gap tick 1, release after 1 tick -> one double_pulse 1 clk after the 2nd released_pulse. No short_pulse.
- Long + repeat: press, hold 10 ticks, release:
  - long_pulse 1 clk after the 4th tick.
  - repeat_pulse after ticks 6, 8, 10 (3 total).
  - No short_pulse on release.
- GAP_TICKS=0: press 1 tick, release -> short_pulse exactly 1 clk after released_pulse.
- Simultaneous events and HELD2 long:
  - released_pulse coincident with 4th tick in HELD -> release path only, no long_pulse.
  - Second press held 4 ticks -> short_pulse and long_pulse high in the same cycle.
- Abort/reset:
  - Drop pb_pressed_status without released_pulse in LONG -> IDLE, held=0, no pulses.
  - Assert rst mid-HELD -> outputs 0 asynchronously. After release, a new 1-tick press/release yields a normal short.

Source files
------------

// File: rtl/button_event_decoder.sv
// button_event_decoder
// Turns the debounced push-button event stream into user gestures for the
// time/alarm set controller: short press, double press, long press and
// auto-repeat while held. All timing is counted in timebase ticks.

module button_event_decoder #(
    parameter int LONG_TICKS   = 1000,
    parameter int REPEAT_TICKS = 200,
    parameter int GAP_TICKS    = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic pb_pressed_pulse,
    input  logic pb_pressed_status,
    input  logic pb_released_pulse,
    output logic short_pulse,
    output logic double_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic held
);

    // Counter must hold the largest threshold value.
    localparam int MAX_LR = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
    localparam int MAX_T  = (MAX_LR > GAP_TICKS) ? MAX_LR : GAP_TICKS;
    localparam int CW     = $clog2(MAX_T + 1);

    // Last counter value before each threshold tick.
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST  = (GAP_TICKS > 0) ? CW'(GAP_TICKS - 1) : {CW{1'b0}};
    localparam bit            GAP_EN    = (GAP_TICKS > 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HELD  = 3'd1,
        ST_LONG  = 3'd2,
        ST_WAIT2 = 3'd3,
        ST_HELD2 = 3'd4
    } state_t;

    state_t          state_r;
    state_t          state_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_s;
    logic            rep_clr_s;
    logic            short_s;
    logic            double_s;
    logic            long_s;
    logic            repeat_s;
    logic            held_s;
    logic            short_r;
    logic            double_r;
    logic            long_r;
    logic            repeat_r;
    logic            held_r;

    // Next-state, pulse and counter decode. Release wins over a coincident
    // threshold tick; a dropped status without a release aborts silently.
    always_comb begin
        state_s   = state_r;
        rep_clr_s = 1'b0;
        short_s   = 1'b0;
        double_s  = 1'b0;
        long_s    = 1'b0;
        repeat_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (pb_pressed_pulse) begin
                    state_s = ST_HELD;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_HELD: begin
                if (pb_released_pulse) begin
                    if (GAP_EN) begin
                        state_s = ST_WAIT2;
                    end else begin
                        short_s = 1'b1;
                        state_s = ST_IDLE;
                    end
                end else if (!pb_pressed_status) begin
                    state_s = ST_IDLE;
                end else if (tick && (cnt_r == LONG_LAST)) begin
                    long_s  = 1'b1;
                    state_s = ST_LONG;
                end else begin
                    state_s = ST_HELD;
                end
            end

            ST_LONG: begin
                if (pb_released_pulse) begin
                    state_s = ST_IDLE;
                end else if (!pb_pressed_status) begin
                    state_s = ST_IDLE;
                end else if (tick && (cnt_r == REP_LAST)) begin
                    repeat_s  = 1'b1;
                    rep_clr_s = 1'b1;
                    state_s   = ST_LONG;
                end else begin
                    state_s = ST_LONG;
                end
            end

            ST_WAIT2: begin
                if (pb_pressed_pulse) begin
                    state_s = ST_HELD2;
                end else if (tick && (cnt_r == GAP_LAST)) begin
                    short_s = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT2;
                end
            end

            ST_HELD2: begin
                if (pb_released_pulse) begin
                    double_s = 1'b1;
                    state_s  = ST_IDLE;
                end else if (!pb_pressed_status) begin
                    state_s = ST_IDLE;
                end else if (tick && (cnt_r == LONG_LAST)) begin
                    // First press was a short; the second one became long.
                    short_s = 1'b1;
                    long_s  = 1'b1;
                    state_s = ST_LONG;
                end else begin
                    state_s = ST_HELD2;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if ((state_s != state_r) || rep_clr_s) begin
            cnt_s = {CW{1'b0}};
        end else if (tick) begin
            cnt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_s = cnt_r;
        end

        held_s = (state_s == ST_HELD) || (state_s == ST_HELD2) || (state_s == ST_LONG);
    end

    // State, tick counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            short_r  <= 1'b0;
            double_r <= 1'b0;
            long_r   <= 1'b0;
            repeat_r <= 1'b0;
            held_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            short_r  <= short_s;
            double_r <= double_s;
            long_r   <= long_s;
            repeat_r <= repeat_s;
            held_r   <= held_s;
        end
    end

    assign short_pulse  = short_r;
    assign double_pulse = double_r;
    assign long_pulse   = long_r;
    assign repeat_pulse = repeat_r;
    assign held         = held_r;

endmodule
